matadd_pipe: RTL and testbench

- Parametrised streaming matrix add/subtract unit: the successor to the fixed 2x3, 32-bit element-wise adder.
- Each accepted beat carries two complete ROWSxCOLS signed matrices plus a per-beat op code.
- Two-stage pipeline with valid/ready flow control on both sides; sustains one matrix per cycle.
- Produces wrapped or saturated results and a per-element signed-overflow mask; sits between operand buffers and downstream matrix consumers in the datapath.

---
 rtl/matadd_pipe.sv | 112 +++++++++++
 tb/tb_matadd_pipe.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/matadd_pipe.sv
// Streaming ROWSxCOLS signed matrix add/subtract with wrap or saturate per beat.
// Two registered stages with valid/ready on both sides; one matrix per cycle.
module matadd_pipe #(
  parameter int ROWS  = 2,
  parameter int COLS  = 3,
  parameter int WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [1:0]                  in_op,
  input  logic [ROWS*COLS*WIDTH-1:0]  in_a,
  input  logic [ROWS*COLS*WIDTH-1:0]  in_b,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ROWS*COLS*WIDTH-1:0]  out_res,
  output logic [ROWS*COLS-1:0]        out_ovf
);

  localparam int N  = ROWS * COLS;
  localparam int DW = N * WIDTH;

  typedef enum logic [1:0] {
    OP_ADD_WRAP = 2'd0,
    OP_SUB_WRAP = 2'd1,
    OP_ADD_SAT  = 2'd2,
    OP_SUB_SAT  = 2'd3
  } op_e;

  logic          s1_valid_q, s1_valid_d;
  logic [DW-1:0] s1_a_q, s1_a_d;
  logic [DW-1:0] s1_b_q, s1_b_d;
  op_e           s1_op_q, s1_op_d;

  logic          s2_valid_q, s2_valid_d;
  logic [DW-1:0] s2_res_q, s2_res_d;
  logic [N-1:0]  s2_ovf_q, s2_ovf_d;

  logic s1_load, s2_load, accept;
  logic op_sub, op_sat;

  // Flow control: S2 drains into the consumer, S1 refills whenever it empties into S2.
  always_comb begin
    s2_load    = s1_valid_q && (!s2_valid_q || out_ready);
    s1_load    = !s1_valid_q || s2_load;
    in_ready   = !rst && s1_load;
    accept     = in_valid && in_ready;
    s1_valid_d = s1_load ? accept : s1_valid_q;
    s1_a_d     = accept ? in_a : s1_a_q;
    s1_b_d     = accept ? in_b : s1_b_q;
    s1_op_d    = accept ? op_e'(in_op) : s1_op_q;
    s2_valid_d = s2_load || (s2_valid_q && !out_ready);
  end

  assign op_sub = (s1_op_q == OP_SUB_WRAP) || (s1_op_q == OP_SUB_SAT);
  assign op_sat = (s1_op_q == OP_ADD_SAT)  || (s1_op_q == OP_SUB_SAT);

  // Each element is evaluated one bit wider so the true result and its overflow are exact.
  always_comb begin
    logic [WIDTH:0] ext_a, ext_b, sum;
    logic           ovf;
    s2_res_d = s2_res_q;
    s2_ovf_d = s2_ovf_q;
    ext_a    = '0;
    ext_b    = '0;
    sum      = '0;
    ovf      = 1'b0;
    if (s2_load) begin
      for (int k = 0; k < N; k++) begin
        ext_a = {s1_a_q[k*WIDTH + WIDTH-1], s1_a_q[k*WIDTH +: WIDTH]};
        ext_b = {s1_b_q[k*WIDTH + WIDTH-1], s1_b_q[k*WIDTH +: WIDTH]};
        sum   = op_sub ? (ext_a - ext_b) : (ext_a + ext_b);
        ovf   = sum[WIDTH] ^ sum[WIDTH-1];
        s2_ovf_d[k] = ovf;
        if (op_sat && ovf)
          s2_res_d[k*WIDTH +: WIDTH] = sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                  : {1'b0, {(WIDTH-1){1'b1}}};
        else
          s2_res_d[k*WIDTH +: WIDTH] = sum[WIDTH-1:0];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
      s2_ovf_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s2_res_q   <= s2_res_d;
      s2_ovf_q   <= s2_ovf_d;
    end
  end

  // NOTE: S1 operands are qualified by s1_valid_q, so they carry no reset; the S2
  // result is reset only because the outputs must read zero straight after reset.
  always_ff @(posedge clk) begin
    s1_a_q  <= s1_a_d;
    s1_b_q  <= s1_b_d;
    s1_op_q <= s1_op_d;
  end

  assign out_valid = s2_valid_q;
  assign out_res   = s2_res_q;
  assign out_ovf   = s2_ovf_q;

endmodule

// File: tb/tb_matadd_pipe.sv
// Scoreboard bench for matadd_pipe at WIDTH=8, 2x3: directed vectors with hand-computed results.
module tb_matadd_pipe;

  localparam int ROWS  = 2;
  localparam int COLS  = 3;
  localparam int WIDTH = 8;
  localparam int N     = ROWS * COLS;
  localparam int DW    = N * WIDTH;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    in_op = 2'd0;
  logic [DW-1:0] in_a = '0;
  logic [DW-1:0] in_b = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_res;
  logic [N-1:0]  out_ovf;

  typedef struct packed {
    logic [DW-1:0] res;
    logic [N-1:0]  ovf;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   run = 0;
  int   max_run = 0;

  always #5 clk = ~clk;

  matadd_pipe #(.ROWS(ROWS), .COLS(COLS), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_ovf   (out_ovf)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic logic [DW-1:0] mk(input int e0, input int e1, input int e2,
                                       input int e3, input int e4, input int e5);
    int          e[6];
    logic [31:0] tmp;
    e  = '{e0, e1, e2, e3, e4, e5};
    mk = '0;
    for (int k = 0; k < N; k++) begin
      tmp = e[k];
      mk[k*WIDTH +: WIDTH] = tmp[WIDTH-1:0];
    end
  endfunction

  function automatic logic [DW-1:0] fill(input int v);
    fill = mk(v, v, v, v, v, v);
  endfunction

  // Offers one beat (caller sits just after a rising edge) and pushes its expected result on accept.
  task automatic send(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [DW-1:0] eres, input logic [N-1:0] eovf);
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(exp_t'{res: eres, ovf: eovf});
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    tests++;
    fails++;
    $display("FAIL send_timeout: in_ready stayed 0 for 100 cycles, expected acceptance");
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(negedge clk);
    check("drain_pending", 64'(exp_q.size()), 64'(0));
    @(posedge clk); #1;
  endtask

  // Monitor: pops the scoreboard on every transfer and checks output stability under backpressure.
  always @(negedge clk) begin : monitor
    exp_t          e;
    logic [DW-1:0] held_res;
    logic [N-1:0]  held_ovf;
    bit            held;
    if (rst) begin
      held = 1'b0;
      run  = 0;
    end else if (out_valid && out_ready) begin
      held = 1'b0;
      run++;
      if (run > max_run) max_run = run;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: got res %h ovf %b, expected no transfer", out_res, out_ovf);
      end else begin
        e = exp_q.pop_front();
        check("out_res", 64'(out_res), 64'(e.res));
        check("out_ovf", 64'(out_ovf), 64'(e.ovf));
      end
    end else begin
      run = 0;
      if (out_valid) begin
        if (held) begin
          check("hold_res", 64'(out_res), 64'(held_res));
          check("hold_ovf", 64'(out_ovf), 64'(held_ovf));
        end
        held     = 1'b1;
        held_res = out_res;
        held_ovf = out_ovf;
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin
    @(negedge clk);
    check("in_ready_during_rst", 64'(in_ready), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready",  64'(in_ready),  64'(1));
    check("rst_out_res",   64'(out_res),   64'(0));
    check("rst_out_ovf",   64'(out_ovf),   64'(0));
    @(posedge clk); #1;

    // Basic add and latency: invisible one cycle after accept, valid the cycle after.
    send(2'd0, fill(5), fill(3), fill(8), 6'b000000);
    @(negedge clk);
    check("latency_early", 64'(out_valid), 64'(0));
    @(negedge clk);
    check("latency_valid", 64'(out_valid), 64'(1));
    @(posedge clk); #1;
    drain();

    // Overflow boundaries, wrap vs saturate, plus a mixed saturating beat.
    send(2'd0, mk(127, 0, 0, 0, 0, 0), mk(1, 0, 0, 0, 0, 0), mk(-128, 0, 0, 0, 0, 0), 6'b000001);
    send(2'd2, mk(127, 0, 0, 0, 0, 0), mk(1, 0, 0, 0, 0, 0), mk(127, 0, 0, 0, 0, 0),  6'b000001);
    send(2'd3, mk(0, 0, 0, 0, 0, -128), mk(0, 0, 0, 0, 0, 1), mk(0, 0, 0, 0, 0, -128), 6'b100000);
    send(2'd1, mk(0, 0, 0, 0, 0, -128), mk(0, 0, 0, 0, 0, 1), mk(0, 0, 0, 0, 0, 127),  6'b100000);
    send(2'd2, mk(100, -100, 50, -1, 127, -128), mk(100, -100, 50, -1, 0, 0),
         mk(127, -128, 100, -2, 127, -128), 6'b000011);
    send(2'd0, fill(-100), fill(-100), fill(56), 6'b111111);
    drain();

    // Back-to-back stream with alternating op.
    max_run = 0;
    run     = 0;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0)
        send(2'd0, mk(10, 20, 30, 40, 50, 60), mk(1, 2, 3, 4, 5, 6),
             mk(11, 22, 33, 44, 55, 66), 6'b000000);
      else
        send(2'd1, mk(10, 20, 30, 40, 50, 60), mk(1, 2, 3, 4, 5, 6),
             mk(9, 18, 27, 36, 45, 54), 6'b000000);
    end
    drain();
    check("stream_consecutive", 64'(max_run), 64'(6));

    // Backpressure: two beats fill the pipe, third waits until the consumer releases.
    out_ready = 1'b0;
    send(2'd0, fill(1), fill(1), fill(2), 6'b000000);
    send(2'd0, fill(2), fill(2), fill(4), 6'b000000);
    in_op    = 2'd0;
    in_a     = fill(3);
    in_b     = fill(3);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", 64'(in_ready),  64'(0));
      check("bp_valid",    64'(out_valid), 64'(1));
      check("bp_res",      64'(out_res),   64'(fill(2)));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(2'd0, fill(3), fill(3), fill(6), 6'b000000);
    drain();

    // Mid-stream reset with both stages full; the beat offered during reset must be dropped.
    out_ready = 1'b0;
    send(2'd0, fill(7), fill(1), fill(8), 6'b000000);
    send(2'd1, fill(7), fill(1), fill(6), 6'b000000);
    in_a     = fill(9);
    in_b     = fill(9);
    in_valid = 1'b1;
    rst      = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", 64'(in_ready), 64'(0));
    @(posedge clk); #1;
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("post_rst_out_valid", 64'(out_valid), 64'(0));
    check("post_rst_in_ready",  64'(in_ready),  64'(1));
    check("post_rst_out_res",   64'(out_res),   64'(0));
    check("post_rst_out_ovf",   64'(out_ovf),   64'(0));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_no_stale", 64'(out_valid), 64'(0));
    end
    @(posedge clk); #1;
    send(2'd0, fill(1), fill(2), fill(3), 6'b000000);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
